// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store alignment controller: size
// encodings, FSM states and the word-boundary crossing test.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  // Size code 2'b11 behaves as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_crossing(input logic [1:0] off, input logic [1:0] size);
    return ({1'b0, off} + size_bytes(size)) > 3'd4;
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Combinational lane logic: in load mode extracts and extends a result from the
// two-word window {w1,w0}; in store mode yields the 8-lane byte mask instead.
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic        i_store_mode,
  input  logic [31:0] i_w0,
  input  logic [31:0] i_w1,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data,
  output logic [7:0]  o_lane_mask
);

  logic [31:0] w_win;
  logic [7:0]  w_base_mask;

  assign w_win = 32'({i_w1, i_w0} >> {i_off, 3'b000});

  always_comb begin
    case (i_size)
      SZ_BYTE: w_base_mask = 8'h01;
      SZ_HALF: w_base_mask = 8'h03;
      default: w_base_mask = 8'h0F;
    endcase
  end

  // NOTE: every output gets a default before the branches so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    o_data      = '0;
    o_lane_mask = '0;
    if (i_store_mode) begin
      o_lane_mask = w_base_mask << i_off;
    end else begin
      case (i_size)
        SZ_BYTE: o_data = {{24{~i_unsigned & w_win[7]}}, w_win[7:0]};
        SZ_HALF: o_data = {{16{~i_unsigned & w_win[15]}}, w_win[15:0]};
        default: o_data = w_win;
      endcase
    end
  end

endmodule

// File: rtl/lsu_align_ctrl.sv
// Load/store alignment controller in front of a word-addressed, async-read data
// memory. Define MISALIGN_TRAP_EN to trap word-crossing accesses instead of splitting.
module lsu_align_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_we,
  input  logic [1:0]      i_req_size,
  input  logic            i_req_unsigned,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic            o_rsp_valid,
  output logic [XLEN-1:0] o_rsp_rdata,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
`ifdef MISALIGN_TRAP_EN
  output logic            o_misaligned,
`endif
  input  logic [XLEN-1:0] i_mem_rdata
);

  state_t            r_state, w_state_nxt;
  logic              r_we, r_uns;
  logic [1:0]        r_size;
  logic [XLEN-1:0]   r_addr, r_wdata, r_w0, r_rsp_rdata;
  logic              w_accept, w_cross, w_enter_resp;
  logic [XLEN-1:0]   w_ext_w0, w_ext_w1, w_ext_data;
  logic [7:0]        w_lane_mask;
  logic [2*XLEN-1:0] w_wdata_sh;
  logic [XLEN-3:0]   w_word_idx, w_word_idx_p1;
`ifdef MISALIGN_TRAP_EN
  logic              r_misaligned;
`endif

  assign o_req_ready   = (r_state == IDLE) && !i_rst;
  assign w_accept      = i_req_valid && o_req_ready;
  assign w_cross       = is_crossing(r_addr[1:0], r_size);
  assign w_word_idx    = r_addr[XLEN-1:2];
  assign w_word_idx_p1 = w_word_idx + (XLEN-2)'(1);
  assign w_wdata_sh    = {{XLEN{1'b0}}, r_wdata} << {r_addr[1:0], 3'b000};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) begin
`ifdef MISALIGN_TRAP_EN
        w_state_nxt = is_crossing(i_req_addr[1:0], i_req_size) ? RESP : ACC0;
`else
        w_state_nxt = ACC0;
`endif
      end
      ACC0:    w_state_nxt = w_cross ? ACC1 : RESP;
      ACC1:    w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_enter_resp = (w_state_nxt == RESP) && (r_state != RESP);

  // The word read this cycle is used directly, so the result is ready on entry to RESP.
  assign w_ext_w0 = (r_state == ACC0) ? i_mem_rdata : r_w0;
  assign w_ext_w1 = (r_state == ACC1) ? i_mem_rdata : '0;

  lsu_load_extract u_extract (
    .i_store_mode (r_we),
    .i_w0         (w_ext_w0),
    .i_w1         (w_ext_w1),
    .i_off        (r_addr[1:0]),
    .i_size       (r_size),
    .i_unsigned   (r_uns),
    .o_data       (w_ext_data),
    .o_lane_mask  (w_lane_mask)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_size      <= SZ_BYTE;
      r_uns       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_w0        <= '0;
      r_rsp_rdata <= '0;
`ifdef MISALIGN_TRAP_EN
      r_misaligned <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we    <= i_req_we;
        r_size  <= i_req_size;
        r_uns   <= i_req_unsigned;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
`ifdef MISALIGN_TRAP_EN
        r_misaligned <= is_crossing(i_req_addr[1:0], i_req_size);
`endif
      end
      if (r_state == ACC0) r_w0 <= i_mem_rdata;
      // Entering RESP straight from IDLE only happens for a trapped access.
      if (w_enter_resp) r_rsp_rdata <= (r_state == IDLE) ? '0 : w_ext_data;
    end
  end

  // Reset suppresses the write even mid-split, so word1 stays untouched.
  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (!i_rst) begin
      case (r_state)
        ACC0: begin
          o_mem_addr = {2'b00, w_word_idx};
          o_mem_we   = r_we;
          if (r_we)
            for (int i = 0; i < XLEN/8; i++)
              o_mem_wdata[8*i +: 8] = w_lane_mask[i] ? w_wdata_sh[8*i +: 8]
                                                     : i_mem_rdata[8*i +: 8];
        end
        ACC1: begin
          o_mem_addr = {2'b00, w_word_idx_p1};
          o_mem_we   = r_we;
          if (r_we)
            for (int i = 0; i < XLEN/8; i++)
              o_mem_wdata[8*i +: 8] = w_lane_mask[4+i] ? w_wdata_sh[XLEN+8*i +: 8]
                                                       : i_mem_rdata[8*i +: 8];
        end
        default: ;
      endcase
    end
  end

  assign o_rsp_valid = (r_state == RESP) && !i_rst;
  assign o_rsp_rdata = r_rsp_rdata;
`ifdef MISALIGN_TRAP_EN
  assign o_misaligned = (r_state == RESP) && r_misaligned && !i_rst;
`endif

endmodule
